lpddr2_avalon_bridge: RTL and testbench

- Sits directly downstream of the CPU top level and consumes its LPDDR2 request bundle: address, write_data, rreq and wreq.
- Returns read_data to the top level.
- Converts each single-word request into one Avalon-MM transaction on the LPDDR2 controller's local port.
- Provides a four-phase completion handshake (ack), calibration gating and a response watchdog.

---
 rtl/lpddr2_avalon_bridge.sv | 165 ++++++++++++++++
 tb/tb_lpddr2_avalon_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr2_avalon_bridge.sv
// lpddr2_avalon_bridge: converts the CPU's level-style single-word LPDDR2
// requests into one Avalon-MM transaction each, with a four-phase ack
// handshake, calibration gating and a read-response watchdog.
// Optional build macro: LPDDR2_RDCACHE_EN adds a single-entry read cache.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_INIT    | waiting for controller calibration (local_init_done)
// S_IDLE    | capturing address/data, waiting for rreq or wreq
// S_WR_CMD  | avl_write asserted, waiting for avl_waitrequest low
// S_RD_CMD  | avl_read asserted, waiting for avl_waitrequest low
// S_RD_WAIT | read accepted, waiting for avl_rdata_valid or timeout
// S_DONE    | ack high, waiting for both requests to drop
module lpddr2_avalon_bridge #(
  parameter int ADDR_W         = 27,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                rreq,
  input  logic                wreq,
  output logic [DATA_W-1:0]   read_data,
  output logic                ack,
  output logic                busy,
  output logic                err,
  input  logic                local_init_done,
  output logic [ADDR_W-1:0]   avl_addr,
  output logic [DATA_W-1:0]   avl_wdata,
  output logic [DATA_W/8-1:0] avl_be,
  output logic [2:0]          avl_burstcount,
  output logic                avl_read,
  output logic                avl_write,
  input  logic                avl_waitrequest,
  input  logic [DATA_W-1:0]   avl_rdata,
  input  logic                avl_rdata_valid
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] ERR_WORD  = DATA_W'(32'hDEADBEEF);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_CMD, S_RD_CMD, S_RD_WAIT, S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;

`ifdef LPDDR2_RDCACHE_EN
  logic [ADDR_W-1:0] cache_tag;
  logic [DATA_W-1:0] cache_data;
  logic              cache_valid;
`endif

  // Single-beat, full-word transfers only.
  assign avl_be         = '1;
  assign avl_burstcount = 3'd1;

  // Request sequencer: all Avalon and CPU-side outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      tmo_cnt   <= '0;
      read_data <= '0;
      ack       <= 1'b0;
      busy      <= 1'b1;
      err       <= 1'b0;
      avl_read  <= 1'b0;
      avl_write <= 1'b0;
      avl_addr  <= '0;
      avl_wdata <= '0;
`ifdef LPDDR2_RDCACHE_EN
      cache_tag   <= '0;
      cache_data  <= '0;
      cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT: begin
          if (local_init_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          // Capture every cycle; the value seen on the request cycle sticks.
          avl_addr  <= address;
          avl_wdata <= write_data;
          if (wreq) begin
            state     <= S_WR_CMD;
            avl_write <= 1'b1;
            busy      <= 1'b1;
          end
`ifdef LPDDR2_RDCACHE_EN
          else if (rreq && cache_valid && (address == cache_tag)) begin
            state     <= S_DONE;
            read_data <= cache_data;
            ack       <= 1'b1;
            busy      <= 1'b1;
          end
`endif
          else if (rreq) begin
            state    <= S_RD_CMD;
            avl_read <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_WR_CMD: begin
          if (!avl_waitrequest) begin
            avl_write <= 1'b0;
            ack       <= 1'b1;
            state     <= S_DONE;
`ifdef LPDDR2_RDCACHE_EN
            if (cache_valid && (avl_addr == cache_tag))
              cache_data <= avl_wdata;
`endif
          end
        end
        S_RD_CMD: begin
          // A valid in the acceptance cycle cannot belong to this read.
          if (!avl_waitrequest) begin
            avl_read <= 1'b0;
            tmo_cnt  <= '0;
            state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (avl_rdata_valid) begin
            read_data <= avl_rdata;
            ack       <= 1'b1;
            state     <= S_DONE;
`ifdef LPDDR2_RDCACHE_EN
            cache_tag   <= avl_addr;
            cache_data  <= avl_rdata;
            cache_valid <= 1'b1;
`endif
          end else if (tmo_cnt == CNT_LAST) begin
            read_data <= ERR_WORD;
            err       <= 1'b1;
            ack       <= 1'b1;
            state     <= S_DONE;
`ifdef LPDDR2_RDCACHE_EN
            cache_valid <= 1'b0;
`endif
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Re-arm only after both requests drop, so a held level never repeats.
          if (!rreq && !wreq) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr2_avalon_bridge.sv
// Directed bench for lpddr2_avalon_bridge (TIMEOUT_CYCLES overridden to 16).
// Define LPDDR2_RDCACHE_EN for both files to exercise the read cache.
module tb_lpddr2_avalon_bridge;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              rreq, wreq;
  logic [DATA_W-1:0] read_data;
  logic              ack, busy, err;
  logic              local_init_done;
  logic [ADDR_W-1:0] avl_addr;
  logic [DATA_W-1:0] avl_wdata;
  logic [3:0]        avl_be;
  logic [2:0]        avl_burstcount;
  logic              avl_read, avl_write;
  logic              avl_waitrequest;
  logic [DATA_W-1:0] avl_rdata;
  logic              avl_rdata_valid;

  int checks   = 0;
  int failures = 0;
  int rd_acc   = 0;
  int wr_acc   = 0;

  lpddr2_avalon_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .rreq(rreq), .wreq(wreq), .read_data(read_data), .ack(ack), .busy(busy),
    .err(err), .local_init_done(local_init_done), .avl_addr(avl_addr),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_burstcount(avl_burstcount),
    .avl_read(avl_read), .avl_write(avl_write), .avl_waitrequest(avl_waitrequest),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid)
  );

  always #5 clk = ~clk;

  // Count accepted Avalon commands at the active edge.
  always @(posedge clk) begin
    if (!rst && avl_read && !avl_waitrequest) rd_acc <= rd_acc + 1;
    if (!rst && avl_write && !avl_waitrequest) wr_acc <= wr_acc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic bad;
    logic seen;
    logic stable;
    int   hi_cnt;

    rst = 1'b1; address = '0; write_data = '0; rreq = 1'b0; wreq = 1'b0;
    local_init_done = 1'b0; avl_waitrequest = 1'b0; avl_rdata = '0; avl_rdata_valid = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 1);
    check("rst_err", err, 0);
    check("rst_rd", avl_read, 0);
    check("rst_wr", avl_write, 0);
    check("rst_rdata", read_data, 0);
    check("rst_addr", avl_addr, 0);
    check("rst_wdata", avl_wdata, 0);
    check("avl_be", avl_be, 4'hF);
    check("avl_burst", avl_burstcount, 3'd1);

    // Calibration gate: request held while calibration not done
    rst = 1'b0; rreq = 1'b1; address = 27'h0000040;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (avl_read || !busy) bad = 1'b1;
    end
    check("cal_gate", bad, 0);
    local_init_done = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (avl_read) seen = 1'b1;
    end
    check("cal_release_rd", seen, 1);
    check("rd_addr", avl_addr, 27'h0000040);

    // Read: data returned 5 cycles after acceptance, rreq held high
    tick();                                  // acceptance edge
    check("rd_drop", avl_read, 0);
    for (int i = 0; i < 4; i++) tick();
    check("rd_noack_early", ack, 0);
    avl_rdata = 32'hCAFEF00D; avl_rdata_valid = 1'b1;
    tick();
    avl_rdata_valid = 1'b0; avl_rdata = 32'h0;
    check("rd_ack", ack, 1);
    check("rd_data", read_data, 32'hCAFEF00D);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!ack || avl_read) bad = 1'b1;
    end
    check("rd_hold_ack", bad, 0);
    check("rd_single_accept", rd_acc, 1);
    rreq = 1'b0;
    tick();
    check("rd_rearm_ack", ack, 0);
    check("rd_rearm_busy", busy, 0);

    // Write with 3 stall cycles; inputs change after capture
    wreq = 1'b1; address = 27'h0000100; write_data = 32'h12345678; avl_waitrequest = 1'b1;
    tick();
    address = 27'h7FFFFFF; write_data = 32'hFFFFFFFF;
    hi_cnt = 0; stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) avl_waitrequest = 1'b0;
      if (avl_write) hi_cnt++;
      if (avl_addr !== 27'h0000100 || avl_wdata !== 32'h12345678 || ack) stable = 1'b0;
      tick();
    end
    check("wr_hold_cycles", hi_cnt, 4);
    check("wr_stable", stable, 1);
    check("wr_ack", ack, 1);
    check("wr_drop", avl_write, 0);
    check("wr_accepts", wr_acc, 1);
    for (int i = 0; i < 5; i++) tick();
    check("wr_hold_ack", ack, 1);
    wreq = 1'b0;
    tick();
    check("wr_rearm", ack, 0);

    // Priority: both requests high -> write only, ack at N+2
    rreq = 1'b1; wreq = 1'b1; address = 27'h0000200; write_data = 32'h00000055;
    tick();
    check("pri_write", avl_write, 1);
    check("pri_no_read", avl_read, 0);
    tick();
    check("pri_ack_n2", ack, 1);
    check("pri_rd_acc", rd_acc, 1);
    check("pri_wr_acc", wr_acc, 2);
    rreq = 1'b0; wreq = 1'b0;
    tick();

    // Timeout: no valid returned
    rreq = 1'b1; address = 27'h0000300;
    tick();                                  // RD_CMD
    tick();                                  // accepted, RD_WAIT
    for (int i = 0; i < 15; i++) tick();
    check("tmo_noack_15", ack, 0);
    tick();
    check("tmo_ack_16", ack, 1);
    check("tmo_data", read_data, 32'hDEADBEEF);
    check("tmo_err", err, 1);
    rreq = 1'b0;
    tick();

    // Successful read after timeout; err stays sticky
    rreq = 1'b1; address = 27'h0000044;
    tick(); tick();
    avl_rdata = 32'h11223344; avl_rdata_valid = 1'b1;
    tick();
    avl_rdata_valid = 1'b0;
    check("post_tmo_data", read_data, 32'h11223344);
    check("post_tmo_err", err, 1);
    rreq = 1'b0;
    tick();

    // Reset during RD_WAIT, stray valid after release
    rreq = 1'b1; address = 27'h0000050;
    tick(); tick();
    check("abort_in_wait", avl_read, 0);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1);
    check("abort_err_clr", err, 0);
    rreq = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    avl_rdata = 32'hBADBAD00; avl_rdata_valid = 1'b1;
    tick();
    avl_rdata_valid = 1'b0;
    tick();
    check("abort_no_ack", ack, 0);
    check("abort_rdata", read_data, 0);
    check("abort_idle", busy, 0);
    check("abort_no_cmd", avl_read, 0);

`ifdef LPDDR2_RDCACHE_EN
    // Read cache: miss fill, hit at N+1, write-through update
    rreq = 1'b1; address = 27'h10;
    tick(); tick();
    avl_rdata = 32'hAAAA5555; avl_rdata_valid = 1'b1;
    tick();
    avl_rdata_valid = 1'b0;
    check("c_miss_data", read_data, 32'hAAAA5555);
    rreq = 1'b0;
    tick();
    hi_cnt = rd_acc;
    rreq = 1'b1;
    tick();
    check("c_hit_ack_n1", ack, 1);
    check("c_hit_data", read_data, 32'hAAAA5555);
    check("c_hit_no_rd", rd_acc, hi_cnt);
    rreq = 1'b0;
    tick();
    wreq = 1'b1; write_data = 32'h1;
    tick(); tick();
    check("c_wr_ack", ack, 1);
    wreq = 1'b0;
    tick();
    rreq = 1'b1;
    tick();
    check("c_upd_ack", ack, 1);
    check("c_upd_data", read_data, 32'h1);
    check("c_upd_no_rd", rd_acc, hi_cnt);
    rreq = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
